// File: rtl/active_list.sv
`default_nettype none
// ============================================================================
//  Module      : active_list
//  Description : In-order reorder buffer (active list) for the OoO core.
//                Allocates one entry per renamed instruction at the tail,
//                marks entries done on execute completion and retires them
//                from the head, one per cycle. On a misprediction flush it
//                walks back from the tail, one entry per cycle. Each walked
//                entry restores the rename map and frees its new preg. The
//                walk then pulses end_flush for one cycle.
//  Ports       : clk, rst (sync, active-high)
//                alloc_*    : allocation handshake and entry payload
//                complete_* : execute completion by slot index
//                flush_*    : flush request and youngest surviving ID
//                commit_*   : registered retire outputs
//                restore_*, freed_new_preg, end_flush : registered walk outputs
//                count      : occupied entries
//  Config      : ACTIVE_LIST_COMMIT_CNT_EN adds commit_count[31:0], a
//                retired-instruction counter cleared only by rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module active_list #(
    parameter int DEPTH  = 32,
    parameter int ID_W   = 32,
    parameter int PREG_W = 6,
    parameter int AREG_W = 5,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    // allocation
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ID_W-1:0]   alloc_id,
    input  logic              alloc_uses_rw,
    input  logic [AREG_W-1:0] alloc_arch_rw,
    input  logic [PREG_W-1:0] alloc_new_preg,
    input  logic [PREG_W-1:0] alloc_old_preg,
    output logic [IDX_W-1:0]  alloc_index,
    // completion
    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_index,
    // flush
    input  logic              flush_req,
    input  logic [ID_W-1:0]   flush_id,
    // commit
    output logic              commit_valid,
    output logic              commit_uses_rw,
    output logic [PREG_W-1:0] commit_old_preg,
    // walk / restore
    output logic              restore_valid,
    output logic              restore_uses_rw,
    output logic [AREG_W-1:0] restore_arch_rw,
    output logic [PREG_W-1:0] restore_preg,
    output logic [PREG_W-1:0] freed_new_preg,
    output logic              end_flush,
    output logic [IDX_W:0]    count
`ifdef ACTIVE_LIST_COMMIT_CNT_EN
    ,
    output logic [31:0]       commit_count
`endif
);

    localparam logic [IDX_W:0]   c_ptr_one = 1;
    localparam logic [IDX_W-1:0] c_idx_one = 1;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WALK = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Pointers carry a wrap bit above the index so full and empty differ.
    logic [IDX_W:0]    r_head;
    logic [IDX_W:0]    r_tail;

    // Per-entry state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [ID_W-1:0]   r_id       [DEPTH];
    logic              r_uses_rw  [DEPTH];
    logic [AREG_W-1:0] r_arch_rw  [DEPTH];
    logic [PREG_W-1:0] r_new_preg [DEPTH];
    logic [PREG_W-1:0] r_old_preg [DEPTH];

    // Flush boundary held for the whole walk; later requests are ignored.
    logic [ID_W-1:0]   r_flush_id;

    // Registered outputs
    logic              r_commit_valid;
    logic              r_commit_uses_rw;
    logic [PREG_W-1:0] r_commit_old_preg;
    logic              r_restore_valid;
    logic              r_restore_uses_rw;
    logic [AREG_W-1:0] r_restore_arch_rw;
    logic [PREG_W-1:0] r_restore_preg;
    logic [PREG_W-1:0] r_freed_new_preg;
    logic              r_end_flush;

    logic              w_empty;
    logic              w_full;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic [IDX_W-1:0]  w_walk_idx;
    logic              w_alloc_ok;
    logic              w_alloc_fire;
    logic              w_commit_fire;
    logic              w_walk_step;
    logic              w_walk_end;
    logic              w_flush_take;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_walk_idx = w_tail_idx - c_idx_one;
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_alloc_ok    = 1'b0;
        w_commit_fire = 1'b0;
        w_walk_step   = 1'b0;
        w_walk_end    = 1'b0;
        w_flush_take  = 1'b0;
        case (r_state)
            S_RUN: begin
                // full uses the pre-update pointers, so a slot freed by a
                // same-cycle commit cannot be reallocated until next cycle.
                w_alloc_ok    = !w_full && !flush_req;
                w_commit_fire = !w_empty && r_valid[w_head_idx] &&
                                r_done[w_head_idx] && !flush_req;
                if (flush_req) begin
                    w_flush_take = 1'b1;
                    w_state_nxt  = S_WALK;
                end
            end
            S_WALK: begin
                if (!w_empty && (r_id[w_walk_idx] > r_flush_id)) begin
                    w_walk_step = 1'b1;
                end else begin
                    w_walk_end  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign alloc_ready  = w_alloc_ok && !rst;
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign alloc_index  = w_tail_idx;
    assign count        = r_tail - r_head;

    // ------------------------------------------------------------------
    // Pointers, entry flags and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head            <= '0;
            r_tail            <= '0;
            r_valid           <= '0;
            r_done            <= '0;
            r_flush_id        <= '0;
            r_commit_valid    <= 1'b0;
            r_commit_uses_rw  <= 1'b0;
            r_commit_old_preg <= '0;
            r_restore_valid   <= 1'b0;
            r_restore_uses_rw <= 1'b0;
            r_restore_arch_rw <= '0;
            r_restore_preg    <= '0;
            r_freed_new_preg  <= '0;
            r_end_flush       <= 1'b0;
        end else begin
            r_commit_valid    <= 1'b0;
            r_commit_uses_rw  <= 1'b0;
            r_commit_old_preg <= '0;
            r_restore_valid   <= 1'b0;
            r_restore_uses_rw <= 1'b0;
            r_restore_arch_rw <= '0;
            r_restore_preg    <= '0;
            r_freed_new_preg  <= '0;
            r_end_flush       <= w_walk_end;

            if (w_flush_take) begin
                r_flush_id <= flush_id;
            end

            // Completion of a slot that is not live is dropped. Later
            // assignments below (alloc, commit, walk) take precedence.
            if (complete_valid && r_valid[complete_index]) begin
                r_done[complete_index] <= 1'b1;
            end

            if (w_alloc_fire) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tail              <= r_tail + c_ptr_one;
            end

            if (w_commit_fire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + c_ptr_one;
                r_commit_valid      <= 1'b1;
                r_commit_uses_rw    <= r_uses_rw[w_head_idx];
                r_commit_old_preg   <= r_old_preg[w_head_idx];
            end

            if (w_walk_step) begin
                r_valid[w_walk_idx] <= 1'b0;
                r_done[w_walk_idx]  <= 1'b0;
                r_tail              <= r_tail - c_ptr_one;
                r_restore_valid     <= 1'b1;
                r_restore_uses_rw   <= r_uses_rw[w_walk_idx];
                r_restore_arch_rw   <= r_arch_rw[w_walk_idx];
                r_restore_preg      <= r_old_preg[w_walk_idx];
                r_freed_new_preg    <= r_new_preg[w_walk_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload: only meaningful while the valid flag is set, so it
    // needs no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_id[w_tail_idx]       <= alloc_id;
            r_uses_rw[w_tail_idx]  <= alloc_uses_rw;
            r_arch_rw[w_tail_idx]  <= alloc_arch_rw;
            r_new_preg[w_tail_idx] <= alloc_new_preg;
            r_old_preg[w_tail_idx] <= alloc_old_preg;
        end
    end

`ifdef ACTIVE_LIST_COMMIT_CNT_EN
    logic [31:0] r_commit_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_count <= '0;
        end else if (w_commit_fire) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    assign commit_count = r_commit_count;
`endif

    assign commit_valid    = r_commit_valid;
    assign commit_uses_rw  = r_commit_uses_rw;
    assign commit_old_preg = r_commit_old_preg;
    assign restore_valid   = r_restore_valid;
    assign restore_uses_rw = r_restore_uses_rw;
    assign restore_arch_rw = r_restore_arch_rw;
    assign restore_preg    = r_restore_preg;
    assign freed_new_preg  = r_freed_new_preg;
    assign end_flush       = r_end_flush;

endmodule
`default_nettype wire

// File: tb/tb_active_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_active_list
//  Description : Self-checking bench for active_list. Entry payload is
//                derived from the ID: arch = id[4:0], old = {0,id[4:0]},
//                new = {1,id[4:0]}, uses_rw = (id % 3 != 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_active_list;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_id;
    logic        alloc_uses_rw;
    logic [4:0]  alloc_arch_rw;
    logic [5:0]  alloc_new_preg;
    logic [5:0]  alloc_old_preg;
    logic [4:0]  alloc_index;
    logic        complete_valid;
    logic [4:0]  complete_index;
    logic        flush_req;
    logic [31:0] flush_id;
    logic        commit_valid;
    logic        commit_uses_rw;
    logic [5:0]  commit_old_preg;
    logic        restore_valid;
    logic        restore_uses_rw;
    logic [4:0]  restore_arch_rw;
    logic [5:0]  restore_preg;
    logic [5:0]  freed_new_preg;
    logic        end_flush;
    logic [5:0]  count;
`ifdef ACTIVE_LIST_COMMIT_CNT_EN
    logic [31:0] commit_count;
`endif

    active_list dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_id        (alloc_id),
        .alloc_uses_rw   (alloc_uses_rw),
        .alloc_arch_rw   (alloc_arch_rw),
        .alloc_new_preg  (alloc_new_preg),
        .alloc_old_preg  (alloc_old_preg),
        .alloc_index     (alloc_index),
        .complete_valid  (complete_valid),
        .complete_index  (complete_index),
        .flush_req       (flush_req),
        .flush_id        (flush_id),
        .commit_valid    (commit_valid),
        .commit_uses_rw  (commit_uses_rw),
        .commit_old_preg (commit_old_preg),
        .restore_valid   (restore_valid),
        .restore_uses_rw (restore_uses_rw),
        .restore_arch_rw (restore_arch_rw),
        .restore_preg    (restore_preg),
        .freed_new_preg  (freed_new_preg),
        .end_flush       (end_flush),
        .count           (count)
`ifdef ACTIVE_LIST_COMMIT_CNT_EN
        ,
        .commit_count    (commit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        av;
        logic [31:0] aid;
        logic        fr;
        logic [31:0] fid;
        logic        cv;
        logic [4:0]  cidx;
        logic        e_rdy;
        logic [4:0]  e_idx;
        logic [5:0]  e_cnt;
        logic        e_rv;
        logic [4:0]  e_rarch;
        logic        e_ef;
        logic        e_cmv;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        flush_req      = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] id);
        alloc_valid    = 1'b1;
        alloc_id       = id;
        alloc_uses_rw  = (id % 3 != 0);
        alloc_arch_rw  = id[4:0];
        alloc_new_preg = {1'b1, id[4:0]};
        alloc_old_preg = {1'b0, id[4:0]};
    endtask

    function automatic vec_t mk(input logic av, input logic [31:0] aid, input logic fr,
                                input logic [31:0] fid, input logic cv, input logic [4:0] cidx,
                                input logic rdy, input logic [4:0] idx, input logic [5:0] cnt,
                                input logic rv, input logic [4:0] rarch, input logic ef,
                                input logic cmv);
        vec_t v;
        v.av = av; v.aid = aid; v.fr = fr; v.fid = fid; v.cv = cv; v.cidx = cidx;
        v.e_rdy = rdy; v.e_idx = idx; v.e_cnt = cnt; v.e_rv = rv; v.e_rarch = rarch;
        v.e_ef = ef; v.e_cmv = cmv;
        return v;
    endfunction

    initial begin
        logic [31:0] id;
        rst = 1'b1;
        idle();
        alloc_id = '0; alloc_uses_rw = 1'b0; alloc_arch_rw = '0;
        alloc_new_preg = '0; alloc_old_preg = '0;
        complete_index = '0; flush_id = '0;

        // ---------------- reset ----------------
        set_alloc(0);
        #1;
        chk("reset_alloc_ready", alloc_ready, 0);
        tick();
        tick();
        chk("reset_count", count, 0);
        chk("reset_commit_valid", commit_valid, 0);
        chk("reset_restore_valid", restore_valid, 0);
        chk("reset_end_flush", end_flush, 0);
        chk("reset_commit_old_preg", commit_old_preg, 0);
        idle();
        rst = 1'b0;
        tick();

        // ---------------- fill 0..31 ----------------
        for (int k = 0; k < 32; k++) begin
            set_alloc(k);
            #1;
            chk("fill_ready", alloc_ready, 1);
            chk("fill_index", alloc_index, k);
            tick();
            chk("fill_count", count, k + 1);
        end
        set_alloc(32);
        #1;
        chk("full_ready", alloc_ready, 0);
        tick();
        chk("full_count", count, 32);
        idle();

        // ---------------- out-of-order completion, in-order commit ----------------
        complete_valid = 1'b1; complete_index = 5'd1;
        tick();
        complete_index = 5'd0;
        tick();
        chk("cmt_none_yet", commit_valid, 0);
        complete_valid = 1'b0;
        tick();
        chk("cmt0_valid", commit_valid, 1);
        chk("cmt0_old", commit_old_preg, 0);
        chk("cmt0_uses", commit_uses_rw, 0);
        tick();
        chk("cmt1_valid", commit_valid, 1);
        chk("cmt1_old", commit_old_preg, 1);
        chk("cmt1_uses", commit_uses_rw, 1);
        chk("cmt_count30", count, 30);
        complete_valid = 1'b1; complete_index = 5'd2;
        tick();
        chk("cmt2_wait", commit_valid, 0);
        complete_index = 5'd3;
        tick();
        chk("cmt2_valid", commit_valid, 1);
        chk("cmt2_old", commit_old_preg, 2);
        complete_valid = 1'b0;
        tick();
        chk("cmt3_old", commit_old_preg, 3);
        chk("cmt_count28", count, 28);
`ifdef ACTIVE_LIST_COMMIT_CNT_EN
        chk("commit_count4", commit_count, 4);
`endif

        // ---------------- wrap: slots 0..3 reused ----------------
        for (int j = 0; j < 4; j++) begin
            set_alloc(32 + j);
            #1;
            chk("wrap_ready", alloc_ready, 1);
            chk("wrap_index", alloc_index, j);
            tick();
        end
        set_alloc(36);
        #1;
        chk("wrap_full_ready", alloc_ready, 0);
        chk("wrap_full_count", count, 32);
        idle();

        // ---------------- full walk: ids 35..5 squashed, id 4 survives ----------------
        flush_req = 1'b1; flush_id = 32'd4;
        tick();
        chk("fw_start_rv", restore_valid, 0);
        flush_req = 1'b0;
        for (int s = 0; s < 31; s++) begin
            id = 32'd35 - s;
            tick();
            chk("fw_rv", restore_valid, 1);
            chk("fw_arch", restore_arch_rw, id[4:0]);
            chk("fw_preg", restore_preg, {1'b0, id[4:0]});
            chk("fw_freed", freed_new_preg, {1'b1, id[4:0]});
            chk("fw_uses", restore_uses_rw, (id % 3 != 0));
            chk("fw_count", count, 31 - s);
            chk("fw_no_ef", end_flush, 0);
        end
        tick();
        chk("fw_end_flush", end_flush, 1);
        chk("fw_end_rv", restore_valid, 0);
        chk("fw_end_count", count, 1);
        chk("fw_resume_ready", alloc_ready, 1);
        tick();
        chk("fw_ef_pulse", end_flush, 0);

        // ---------------- table: alloc 0..9, flush_id=4 with same-cycle alloc ----------------
        for (int k = 0; k < 9; k++) begin
            tbl[k] = mk(1, k, 0, 0, 0, 0, 1, k[4:0], 6'(k + 1), 0, 0, 0, 0);
        end
        tbl[9]  = mk(1,  9, 0, 0, 1, 0, 1,  9, 10, 0, 0, 0, 0);
        tbl[10] = mk(1, 10, 1, 4, 0, 0, 0, 10, 10, 0, 0, 0, 0);
        tbl[11] = mk(1, 11, 1, 0, 0, 0, 0, 10,  9, 1, 9, 0, 0);
        tbl[12] = mk(0,  0, 0, 0, 0, 0, 0,  9,  8, 1, 8, 0, 0);
        tbl[13] = mk(0,  0, 0, 0, 0, 0, 0,  8,  7, 1, 7, 0, 0);
        tbl[14] = mk(0,  0, 0, 0, 0, 0, 0,  7,  6, 1, 6, 0, 0);
        tbl[15] = mk(0,  0, 0, 0, 0, 0, 0,  6,  5, 1, 5, 0, 0);
        tbl[16] = mk(1, 12, 0, 0, 0, 0, 0,  5,  5, 0, 0, 1, 0);
        tbl[17] = mk(0,  0, 0, 0, 0, 0, 1,  5,  4, 0, 0, 0, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 18; r++) begin
            if (tbl[r].av) set_alloc(tbl[r].aid);
            else alloc_valid = 1'b0;
            flush_req      = tbl[r].fr;
            flush_id       = tbl[r].fid;
            complete_valid = tbl[r].cv;
            complete_index = tbl[r].cidx;
            #1;
            chk("tbl_ready", alloc_ready, tbl[r].e_rdy);
            chk("tbl_index", alloc_index, tbl[r].e_idx);
            tick();
            chk("tbl_count", count, tbl[r].e_cnt);
            chk("tbl_rv", restore_valid, tbl[r].e_rv);
            chk("tbl_rarch", restore_arch_rw, tbl[r].e_rarch);
            chk("tbl_rpreg", restore_preg, tbl[r].e_rv ? {1'b0, tbl[r].e_rarch} : 6'd0);
            chk("tbl_freed", freed_new_preg, tbl[r].e_rv ? {1'b1, tbl[r].e_rarch} : 6'd0);
            chk("tbl_ruses", restore_uses_rw, tbl[r].e_rv && (tbl[r].e_rarch % 3 != 0));
            chk("tbl_ef", end_flush, tbl[r].e_ef);
            chk("tbl_cmv", commit_valid, tbl[r].e_cmv);
        end
        idle();

        // ---------------- reset mid-walk ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_alloc(k);
            tick();
        end
        idle();
        flush_req = 1'b1; flush_id = 32'd0;
        tick();
        flush_req = 1'b0;
        tick();
        tick();
        chk("mw_walking", restore_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mw_count", count, 0);
        chk("mw_rv", restore_valid, 0);
        chk("mw_ef", end_flush, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mw_no_ef", end_flush, 0);
            chk("mw_no_rv", restore_valid, 0);
        end
        chk("mw_ready", alloc_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
